// File: rtl/function_unmix_seq.sv
// Multi-cycle decoder for mixed-mode words: recovers x (and y for interleave) from an encoded word.
// One decode step per cycle; result held in DONE until the consumer takes it.
module function_unmix_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_y,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic             out_err
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  localparam logic [1:0] MODE_ADD   = 2'b00;
  localparam logic [1:0] MODE_ILV   = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] yin_q, yin_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      yin_q   <= '0;
      mode_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      yin_q   <= yin_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    yin_d   = yin_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          yin_d   = in_y;
          mode_d  = in_mode;
          x_d     = '0;
          y_d     = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        case (mode_q)
          MODE_ADD: begin
            x_d     = data_q - yin_q;
            state_d = S_DONE;
          end
          MODE_ILV: begin
            // Step cnt_q de-interleaves bit pair cnt_q into bit cnt_q of x and y.
            for (int i = 0; i < HALF; i++) begin
              if (cnt_q == CW'(i)) begin
                x_d[i] = data_q[2*i];
                y_d[i] = data_q[2*i+1];
              end
            end
            if (cnt_q == LAST) state_d = S_DONE;
            else               cnt_d   = cnt_q + CW'(1);
          end
          MODE_SHIFT: begin
            x_d     = data_q >> 1;
            state_d = S_DONE;
          end
          default: begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        endcase
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_err   = err_q;

endmodule
